// File: rtl/axilm_arb.sv
// Round-robin arbiter sharing the single AXI4-Lite master user port among NUM_REQ requesters.
// Optional watchdog, enabled by defining AXILM_ARB_TIMEOUT_EN, aborts stalled transactions with SLVERR.
module axilm_arb #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic [NUM_REQ-1:0]         REQ_VALID,
   input  logic [NUM_REQ-1:0]         REQ_WRITE,
   input  logic [4*NUM_REQ-1:0]       REQ_WSTB,
   input  logic [32*NUM_REQ-1:0]      REQ_ADDR,
   input  logic [32*NUM_REQ-1:0]      REQ_WDATA,
   output logic [NUM_REQ-1:0]         REQ_ACK,
   output logic [31:0]                REQ_RDATA,
   output logic [1:0]                 REQ_RESP,
   output logic                       M_ENA,
   output logic                       M_WRITE,
   output logic [3:0]                 M_WSTB,
   output logic [31:0]                M_ADDR,
   output logic [31:0]                M_WDATA,
   input  logic [31:0]                M_RDATA,
   input  logic [1:0]                 M_RESP,
   input  logic                       M_DONE,
   output logic                       BUSY,
   output logic [$clog2(NUM_REQ)-1:0] GRANT_ID,
   output logic                       TO_ERR
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] pick_id;
   logic            pick_found;
   logic [ID_W:0]   scan;
   logic            to_hit;

   // Cyclic search for the first pending requester at or above the rotating pointer.
   always_comb begin
      pick_id    = '0;
      pick_found = 1'b0;
      scan       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, ptr} + (ID_W+1)'(k);
         if (scan >= (ID_W+1)'(NUM_REQ)) begin
            scan = scan - (ID_W+1)'(NUM_REQ);
         end
         if (!pick_found && REQ_VALID[scan[ID_W-1:0]]) begin
            pick_found = 1'b1;
            pick_id    = scan[ID_W-1:0];
         end
      end
   end

`ifdef AXILM_ARB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [TO_W-1:0] to_cnt;
   logic            to_err_q;

   // Watchdog counts WAIT cycles; a same-cycle M_DONE takes precedence over expiry.
   assign to_hit = (state == WAIT) && !M_DONE && (to_cnt == TO_W'(TIMEOUT-1));

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         to_cnt   <= '0;
         to_err_q <= 1'b0;
      end else begin
         if (state == ISSUE) begin
            to_cnt <= '0;
         end else if (state == WAIT && !M_DONE && !to_hit) begin
            to_cnt <= to_cnt + TO_W'(1);
         end
         if (to_hit) begin
            to_err_q <= 1'b1;
         end
      end
   end

   assign TO_ERR = to_err_q;
`else
   assign to_hit = 1'b0;
   assign TO_ERR = 1'b0;
`endif

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_found) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (M_DONE || to_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command is latched once at grant and held until the machine is back in IDLE.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         ptr       <= '0;
         GRANT_ID  <= '0;
         M_WRITE   <= 1'b0;
         M_WSTB    <= '0;
         M_ADDR    <= '0;
         M_WDATA   <= '0;
         REQ_RDATA <= '0;
         REQ_RESP  <= '0;
      end else begin
         if (state == IDLE && pick_found) begin
            GRANT_ID <= pick_id;
            M_WRITE  <= REQ_WRITE[pick_id];
            M_WSTB   <= REQ_WSTB[{pick_id, 2'b00} +: 4];
            M_ADDR   <= REQ_ADDR[{pick_id, 5'b00000} +: 32];
            M_WDATA  <= REQ_WDATA[{pick_id, 5'b00000} +: 32];
         end
         if (state == WAIT && M_DONE) begin
            REQ_RDATA <= M_WRITE ? 32'h0 : M_RDATA;
            REQ_RESP  <= M_RESP;
         end else if (to_hit) begin
            REQ_RDATA <= 32'h0;
            REQ_RESP  <= 2'b10;
         end
         if (state == RESP) begin
            ptr <= (GRANT_ID == ID_W'(NUM_REQ-1)) ? '0 : GRANT_ID + ID_W'(1);
         end
      end
   end

   assign M_ENA   = (state == ISSUE);
   assign BUSY    = (state != IDLE);
   assign REQ_ACK = (state == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << GRANT_ID) : '0;

endmodule
